// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and helpers for the programmable sequence detector family
package seq_det_pkg;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } det_state_t;

    // Width needed to hold a length value in the range 0..max_len
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // A pattern length is usable only if it spans at least two bits and fits the shift register
    function automatic logic len_ok(input int len, input int max_len);
        return (len >= 2) && (len <= max_len);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    // Clear wins over increment; the count sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - runtime-programmable serial bit-pattern detector
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = len_w(MAX_LEN),
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               en,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               clr_cnt,
    output logic               match,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [LEN_W-1:0]   fill,
    output logic               armed
);

    det_state_t         state;
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   len;
    logic               overlap;

    logic               cfg_ok;
    logic               cfg_accept;
    logic               bit_accept;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_n;
    logic [MAX_LEN-1:0] mask;
    logic               hit;

    assign cfg_ok     = len_ok(int'(cfg_len), MAX_LEN);
    assign cfg_accept = cfg_we && cfg_ok;
    // A bit counts only while running, enabled, and not colliding with a config write
    assign bit_accept = (state == RUN) && en && in_valid && !cfg_we;
    assign hist_n     = {hist[MAX_LEN-2:0], in_bit};
    assign fill_inc   = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    assign fill_n     = (fill_inc > {1'b0, len}) ? len : fill_inc[LEN_W-1:0];
    assign armed      = (state == RUN);

    // Mask selects the low len bits; built bitwise so len == MAX_LEN needs no wide shift
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    // Masked pattern compare on the would-be next history
    always_comb begin
        hit = 1'b0;
        if (bit_accept && (fill_n == len) && (((hist_n ^ pattern) & mask) == '0)) begin
            hit = 1'b1;
        end
    end

    // Control FSM, config latch, history/fill tracking and registered pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= UNCFG;
            hist    <= '0;
            fill    <= '0;
            pattern <= '0;
            len     <= '0;
            overlap <= 1'b0;
            match   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            match   <= 1'b0;
            cfg_err <= 1'b0;
            if (cfg_we) begin
                if (cfg_ok) begin
                    pattern <= cfg_pattern;
                    len     <= cfg_len;
                    overlap <= cfg_overlap;
                    hist    <= '0;
                    fill    <= '0;
                    state   <= en ? RUN : PAUSE;
                end else begin
                    cfg_err <= 1'b1;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (!en) begin
                            state <= PAUSE;
                        end else if (in_valid) begin
                            hist  <= hist_n;
                            match <= hit;
                            if (hit && !overlap) begin
                                fill <= '0;
                            end else begin
                                fill <= fill_n;
                            end
                        end
                    end
                    PAUSE: begin
                        if (en) begin
                            state <= RUN;
                        end
                    end
                    default: begin
                        state <= UNCFG;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .clr(cfg_accept || clr_cnt),
        .inc(hit),
        .q  (match_cnt)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - directed self-checking bench for seq_detector_prog
module tb_seq_detector_prog;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               en;
    logic               in_valid;
    logic               in_bit;
    logic               clr_cnt;

    logic               cfg_err, cfg_err2;
    logic               match, match2;
    logic [7:0]         match_cnt;
    logic [1:0]         match_cnt2;
    logic [LEN_W-1:0]   fill, fill2;
    logic               armed, armed2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
        .en(en), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
        .match(match), .match_cnt(match_cnt), .fill(fill), .armed(armed)
    );

    seq_detector_prog #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err2),
        .en(en), .in_valid(in_valid), .in_bit(in_bit), .clr_cnt(clr_cnt),
        .match(match2), .match_cnt(match_cnt2), .fill(fill2), .armed(armed2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        cfg_we      = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ov;
        tick();
        cfg_we      = 1'b0;
    endtask

    task automatic send(input logic b);
        in_valid = 1'b1;
        in_bit   = b;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] s;
        logic [7:0] m;
        logic [7:0] f;

        rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        en = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
        tick(); tick();
        chk("rst_match", match, 0);
        chk("rst_cnt", match_cnt, 0);
        chk("rst_fill", fill, 0);
        chk("rst_armed", armed, 0);
        chk("rst_cfg_err", cfg_err, 0);
        rst = 1'b0;
        tick();
        chk("uncfg_armed", armed, 0);

        // overlapping 0101 over 01010101: hits after bits 4, 6, 8
        cfg(8'b0101, 4'd4, 1'b1);
        chk("ov_armed", armed, 1);
        chk("ov_cfg_err", cfg_err, 0);
        s = 8'b0101_0101; m = 8'b0001_0101;
        for (int i = 0; i < 8; i++) begin
            send(s[7-i]);
            chk($sformatf("ov_match_b%0d", i + 1), match, m[7-i]);
        end
        chk("ov_fill", fill, 4);
        chk("ov_cnt", match_cnt, 3);

        // non-overlapping: hits after bits 4 and 8 only, fill returns to 0
        cfg(8'b0101, 4'd4, 1'b0);
        chk("nov_cnt_cleared", match_cnt, 0);
        m = 8'b0001_0001;
        for (int i = 0; i < 8; i++) begin
            send(s[7-i]);
            chk($sformatf("nov_match_b%0d", i + 1), match, m[7-i]);
            chk($sformatf("nov_fill_b%0d", i + 1), fill, (i % 4 == 3) ? 0 : (i % 4) + 1);
        end
        chk("nov_cnt", match_cnt, 2);

        // illegal lengths rejected from UNCFG, then a legal len=3 config
        rst = 1'b1; tick(); rst = 1'b0;
        cfg(8'b0, 4'd1, 1'b1);
        chk("len1_err", cfg_err, 1);
        chk("len1_armed", armed, 0);
        tick();
        chk("err_one_cycle", cfg_err, 0);
        cfg(8'hFF, 4'd9, 1'b1);
        chk("len9_err", cfg_err, 1);
        chk("len9_armed", armed, 0);
        send(1'b0); send(1'b1); send(1'b0);
        send(1'b1);
        chk("uncfg_no_match", match, 0);
        chk("uncfg_fill", fill, 0);
        cfg(8'b110, 4'd3, 1'b1);
        chk("len3_err", cfg_err, 0);
        send(1'b1); chk("len3_b1", match, 0);
        send(1'b1); chk("len3_b2", match, 0);
        send(1'b0); chk("len3_b3", match, 1);
        chk("len3_cnt", match_cnt, 1);

        // valid bits separated by 3 idle cycles
        cfg(8'b0101, 4'd4, 1'b1);
        s = 8'b0101_0000; m = 8'b0001_0000;
        for (int i = 0; i < 4; i++) begin
            send(s[7-i]);
            chk($sformatf("gap_match_b%0d", i + 1), match, m[7-i]);
            for (int j = 0; j < 3; j++) begin
                tick();
                chk($sformatf("gap_idle_b%0d_%0d", i + 1, j), match, 0);
            end
        end
        chk("gap_cnt", match_cnt, 1);

        // reset mid-pattern discards the partial match
        cfg(8'b0101, 4'd4, 1'b1);
        send(1'b0); send(1'b1); send(1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_armed", armed, 0);
        chk("midrst_fill", fill, 0);
        chk("midrst_cnt", match_cnt, 0);
        cfg(8'b0101, 4'd4, 1'b1);
        send(1'b1);
        chk("midrst_match", match, 0);
        chk("midrst_fill1", fill, 1);
        chk("midrst_cnt1", match_cnt, 0);

        // en dropping with a valid bit: bit dropped, move to PAUSE, resume later
        cfg(8'b0101, 4'd4, 1'b1);
        send(1'b0); send(1'b1); send(1'b0);
        en = 1'b0;
        send(1'b1);
        chk("pause_armed", armed, 0);
        chk("pause_match", match, 0);
        chk("pause_fill", fill, 3);
        send(1'b1);
        chk("pause_hold_fill", fill, 3);
        en = 1'b1;
        tick();
        chk("resume_armed", armed, 1);
        send(1'b1);
        chk("resume_match", match, 1);

        // saturation: pattern 11 overlapping, six 1s -> 5 hits
        cfg(8'b11, 4'd2, 1'b1);
        m = 8'b0111_1100;
        f = 8'b0;
        for (int i = 0; i < 6; i++) begin
            send(1'b1);
            chk($sformatf("sat_match_b%0d", i + 1), match2, m[7-i]);
            if (m[7-i] && f < 8'd3) f = f + 8'd1;
            chk($sformatf("sat_cnt2_b%0d", i + 1), match_cnt2, f);
        end
        chk("sat_cnt2_final", match_cnt2, 3);
        chk("sat_cnt8_final", match_cnt, 5);
        clr_cnt = 1'b1;
        send(1'b1);
        clr_cnt = 1'b0;
        chk("clr_hit_match", match, 1);
        chk("clr_hit_cnt8", match_cnt, 0);
        chk("clr_hit_cnt2", match_cnt2, 0);

        // rejected write in RUN keeps state and config
        cfg(8'b0, 4'd0, 1'b0);
        chk("run_rej_err", cfg_err, 1);
        chk("run_rej_armed", armed, 1);
        send(1'b1);
        chk("run_rej_match", match, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
